// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes and
// datapath mux/ALU select codes.
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ, S_ILLEGAL
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b010;
    localparam logic [2:0] ALUC_AND = 3'b011;
    localparam logic [2:0] ALUC_OR  = 3'b100;
    localparam logic [2:0] ALUC_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the controller's alu_op plus instruction funct fields to the ALU
// operation code.
module alu_decoder
    import rv_mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);
    always_comb begin
        alu_control_o = ALUC_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALUC_ADD;
            ALUOP_SUB: alu_control_o = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // op5 distinguishes R-type from addi, whose funct7 is immediate bits
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control_o = ALUC_SLT;
                    3'b110:  alu_control_o = ALUC_OR;
                    3'b111:  alu_control_o = ALUC_AND;
                    default: alu_control_o = ALUC_ADD;
                endcase
            end
            default: alu_control_o = ALUC_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath.
// Optional memory handshake stalls: define MC_MEM_WAIT_EN.
module multicycle_controller
    import rv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_w,
    output logic       ir_w,
    output logic       reg_w,
    output logic       mem_w,
    output logic       mem_req,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal
);
    state_e     state_q, state_d;
    logic       pc_update, branch, rdy;
    logic [1:0] alu_op;

`ifdef MC_MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign rdy              = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                ir_w       = rdy;
                pc_update  = rdy;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // alu_out captures old_pc + imm: the branch/jal target
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op_code)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_code == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_w      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (rdy) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC loads the target from alu_out while the ALU forms the link address
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_w = pc_update | (branch & zero);

    always_comb begin
        case (op_code)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7[5]),
        .op5_i         (op_code[5]),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against a per-instruction
// cycle-table model of the expected control outputs.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, mem_ready;
    logic       pc_w, ir_w, reg_w, mem_w, mem_req, adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;

    int checks   = 0;
    int failures = 0;
    logic [6:0] prev_op = 7'b0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .pc_w(pc_w), .ir_w(ir_w), .reg_w(reg_w),
        .mem_w(mem_w), .mem_req(mem_req), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] opcode_of(input int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_JAL:   return 7'b1101111;
            K_BEQ:   return 7'b1100011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int latency_of(input int kind);
        case (kind)
            K_LW:             return 5;
            K_BEQ, K_ILL:     return 3;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] alu_f(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b5) ? 3'b010 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b100;
            3'b111:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // {pc_w,ir_w,reg_w,mem_w,mem_req,adr_src,a,b,result_src,alu_control,illegal,imm_src}
    function automatic logic [17:0] exp_vec(input int kind, input int c, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7, input logic z);
        logic pcw, irw, rw, mw, mr, ad, il;
        logic [1:0] a, b, rs;
        logic [2:0] ac;
        {pcw, irw, rw, mw, mr, ad, il} = '0;
        a = 2'b00; b = 2'b00; rs = 2'b00; ac = 3'b000;
        if (c == 1) begin
            mr = 1; irw = 1; pcw = 1; b = 2'b10; rs = 2'b10;
        end else if (c == 2) begin
            a = 2'b01; b = 2'b01;
        end else begin
            case (kind)
                K_LW, K_SW: begin
                    if (c == 3) begin a = 2'b10; b = 2'b01; end
                    else if (c == 4) begin mr = 1; ad = 1; mw = (kind == K_SW); end
                    else begin rs = 2'b01; rw = 1; end
                end
                K_R, K_I: begin
                    if (c == 3) begin
                        a = 2'b10; b = (kind == K_I) ? 2'b01 : 2'b00;
                        ac = alu_f(f3, f7[5], kind == K_R);
                    end else rw = 1;
                end
                K_JAL: begin
                    if (c == 3) begin a = 2'b01; b = 2'b10; pcw = 1; end
                    else rw = 1;
                end
                K_BEQ: begin a = 2'b10; ac = 3'b010; pcw = z; end
                default: il = 1;
            endcase
        end
        return {pcw, irw, rw, mw, mr, ad, a, b, rs, ac, il, imm_of(op)};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {pc_w, ir_w, reg_w, mem_w, mem_req, adr_src, alu_src_a, alu_src_b,
                result_src, alu_control, illegal, imm_src};
    endfunction

    task automatic chk(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = obs_vec();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic drive_ready();
`ifdef MC_MEM_WAIT_EN
        return 1'b1;
`else
        return 1'($urandom);
`endif
    endfunction

    // Entered mid-cycle with the controller in FETCH; leaves it mid-cycle in FETCH.
    task automatic run_instr(input string name, input int kind, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7, input logic zv,
                             input int abort_c, input int fwait);
        int n;
        n = latency_of(kind);
        for (int c = 1; c <= n; c++) begin
            if (c == 1) begin
                for (int w = 0; w < fwait; w++) begin
                    op_code = prev_op; funct3 = 3'($urandom); funct7 = 7'($urandom);
                    zero = 1'($urandom); mem_ready = 1'b0;
                    #1;
                    chk($sformatf("%s fetchwait%0d", name, w),
                        exp_vec(kind, 1, prev_op, 3'b0, 7'b0, 1'b0) & ~18'h30000);
                    @(posedge clk); #1;
                end
            end
            op_code   = (c == 1) ? prev_op : op;
            funct3    = (c == 1) ? 3'($urandom) : f3;
            funct7    = (c == 1) ? 7'($urandom) : f7;
            zero      = (kind == K_BEQ && c == 3) ? zv : 1'($urandom);
            mem_ready = drive_ready();
            #1;
            chk($sformatf("%s c%0d", name, c), exp_vec(kind, c, op_code, funct3, funct7, zero));
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("%s rst_async", name), exp_vec(kind, 1, op_code, 3'b0, 7'b0, 1'b0));
                @(posedge clk); #1;
                chk($sformatf("%s rst_hold", name), exp_vec(kind, 1, op_code, 3'b0, 7'b0, 1'b0));
                rst_n = 1'b1;
                prev_op = op;
                return;
            end
            @(posedge clk); #1;
        end
        prev_op = op;
    endtask

    initial begin
        int kind;
        logic [6:0] op, f7;
        logic [2:0] f3;
        rst_n = 1'b0; op_code = 7'b0; funct3 = 3'b0; funct7 = 7'b0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset", exp_vec(K_LW, 1, 7'b0, 3'b0, 7'b0, 1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr("lw",      K_LW,  opcode_of(K_LW),  3'b010, 7'b0,       1'b0, 0, 0);
        run_instr("add",     K_R,   opcode_of(K_R),   3'b000, 7'b0000000, 1'b0, 0, 0);
        run_instr("sub",     K_R,   opcode_of(K_R),   3'b000, 7'b0100000, 1'b0, 0, 0);
        run_instr("addi_f7", K_I,   opcode_of(K_I),   3'b000, 7'b0100000, 1'b0, 0, 0);
        run_instr("beq_t",   K_BEQ, opcode_of(K_BEQ), 3'b000, 7'b0,       1'b1, 0, 0);
        run_instr("beq_nt",  K_BEQ, opcode_of(K_BEQ), 3'b000, 7'b0,       1'b0, 0, 0);
        run_instr("jal",     K_JAL, opcode_of(K_JAL), 3'b000, 7'b0,       1'b0, 0, 0);
        run_instr("illegal", K_ILL, 7'b0000000,       3'b000, 7'b0,       1'b0, 0, 0);
        run_instr("sw_rst",  K_SW,  opcode_of(K_SW),  3'b010, 7'b0,       1'b0, 4, 0);
        run_instr("sw",      K_SW,  opcode_of(K_SW),  3'b010, 7'b0,       1'b0, 0, 0);
`ifdef MC_MEM_WAIT_EN
        run_instr("lw_wait", K_LW,  opcode_of(K_LW),  3'b010, 7'b0,       1'b0, 0, 2);
`endif

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 6));
            op = opcode_of(kind);
            if (kind == K_ILL) begin
                do op = 7'($urandom);
                while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                       op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011);
            end
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0100000;
            if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
            run_instr($sformatf("rnd%0d", i), kind, op, f3, f7, 1'($urandom),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, latency_of(kind))) : 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
